// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the I2C bus arbiter.
//   - state encoding of the arbiter FSM (IDLE=0 .. GAP=4)
//   - descriptor field widths and the latched transaction descriptor struct
package i2c_arb_pkg;

  localparam int CHIP_W = 7;
  localparam int REG_W  = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  // One byte transaction as handed to the I2C master.
  typedef struct packed {
    logic              rw;
    logic [CHIP_W-1:0] chip;
    logic [REG_W-1:0]  reg_a;
    logic [DATA_W-1:0] wdata;
  } i2c_desc_t;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and master-side signals of the I2C bus arbiter.
//   slave  : arbiter view (takes requests and master status, drives grants,
//            completion, and the launch/abort/descriptor to the master)
//   master : environment view (requesters plus the I2C byte master)
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import i2c_arb_pkg::*;

  // requesters
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [CHIP_W*NUM_REQ-1:0] req_chip;
  logic [REG_W*NUM_REQ-1:0]  req_reg;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic                      timeout;
  logic                      busy;

  // I2C byte master
  logic                      m_start;
  logic                      m_rw;
  logic [CHIP_W-1:0]         m_chip;
  logic [REG_W-1:0]          m_reg;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_abort;
  logic                      m_done;
  logic                      m_nack;
  logic [DATA_W-1:0]         m_rdata;

  modport slave (
    input  req, req_rw, req_chip, req_reg, req_wdata, m_done, m_nack, m_rdata,
    output gnt, done, rdata, err, timeout, busy,
           m_start, m_rw, m_chip, m_reg, m_wdata, m_abort
  );

  modport master (
    output req, req_rw, req_chip, req_reg, req_wdata, m_done, m_nack, m_rdata,
    input  gnt, done, rdata, err, timeout, busy,
           m_start, m_rw, m_chip, m_reg, m_wdata, m_abort
  );

endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req : request levels
//   ptr : highest-priority index this round
//   gnt : one-hot winner (first requester at or after ptr, wrapping)
//   idx : binary index of the winner
//   any : at least one request present
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Two passes: indices >= ptr first, then the wrapped ones below ptr.
  // Once the first pass finds a winner the second pass is masked by any.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C byte master between NUM_REQ requesters.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : requester descriptors/grants/completion and master handshake
// Round-robin grant, one-cycle m_start launch, watchdog with m_abort, and a
// forced idle gap between transactions.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 600,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  i2c_bus_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               timeout_q, timeout_d;
  logic               m_start_q, m_start_d;
  i2c_desc_t          desc_q, desc_d;
  logic               m_abort;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // Per-requester descriptor unpacked from the flat request buses.
  i2c_desc_t req_desc [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_desc
    assign req_desc[i] = '{
      rw:    bus.req_rw[i],
      chip:  bus.req_chip[i*CHIP_W +: CHIP_W],
      reg_a: bus.req_reg[i*REG_W +: REG_W],
      wdata: bus.req_wdata[i*DATA_W +: DATA_W]
    };
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = '0;
    rdata_d   = rdata_q;
    desc_d    = desc_q;
    err_d     = 1'b0;      // err/timeout live only for the done cycle
    timeout_d = 1'b0;
    done_d    = '0;
    m_start_d = 1'b0;
    m_abort   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_ISSUE;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          desc_d  = req_desc[pick_idx];
        end
      end

      ST_ISSUE: begin
        // Registered, so the launch pulse lines up with the first WAIT cycle.
        m_start_d = 1'b1;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // m_done has priority over the watchdog firing in the same cycle.
        if (bus.m_done) begin
          rdata_d = bus.m_rdata;
          err_d   = bus.m_nack;
          done_d  = gnt_q;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          m_abort   = 1'b1;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          done_d    = gnt_q;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        gnt_d    = '0;
        state_d  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      m_start_q <= 1'b0;
      desc_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      m_start_q <= m_start_d;
      desc_q    <= desc_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.m_start = m_start_q;
  assign bus.m_abort = m_abort;
  assign bus.m_rw    = desc_q.rw;
  assign bus.m_chip  = desc_q.chip;
  assign bus.m_reg   = desc_q.reg_a;
  assign bus.m_wdata = desc_q.wdata;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed steps plus randomized
// transactions, with the bench acting as requesters and as the I2C master.
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int N   = 2;
  localparam int GAP = 8;
  localparam int TO  = 100;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  i2c_bus_arbiter #(
    .NUM_REQ        (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model state
  int                ptr_m;
  logic [7:0]        rdata_m;
  logic              rw_m   [N];
  logic [CHIP_W-1:0] chip_m [N];
  logic [REG_W-1:0]  reg_m  [N];
  logic [DATA_W-1:0] wd_m   [N];

  int n_chk, n_pass, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First requester at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive_desc();
    for (int i = 0; i < N; i++) begin
      bus.req_rw[i]                       = rw_m[i];
      bus.req_chip[i*CHIP_W +: CHIP_W]    = chip_m[i];
      bus.req_reg[i*REG_W +: REG_W]       = reg_m[i];
      bus.req_wdata[i*DATA_W +: DATA_W]   = wd_m[i];
    end
  endtask

  task automatic set_desc(input int i, input logic rw, input logic [6:0] c,
                          input logic [7:0] r, input logic [7:0] w);
    rw_m[i] = rw; chip_m[i] = c; reg_m[i] = r; wd_m[i] = w;
    drive_desc();
  endtask

  // Called while the DUT is idle with req applied; ends in WAIT cycle 1.
  task automatic start_txn(output int g);
    g = pick(bus.req, ptr_m);
    tick();
    chk("gnt", 32'(bus.gnt), 32'(1 << g));
    chk("busy_issue", 32'(bus.busy), 1);
    chk("m_start_early", 32'(bus.m_start), 0);
    chk("m_chip", 32'(bus.m_chip), 32'(chip_m[g]));
    chk("m_reg", 32'(bus.m_reg), 32'(reg_m[g]));
    chk("m_wdata", 32'(bus.m_wdata), 32'(wd_m[g]));
    chk("m_rw", 32'(bus.m_rw), 32'(rw_m[g]));
    tick();
    chk("m_start", 32'(bus.m_start), 1);
  endtask

  // Master answers on WAIT cycle d (d > TO: never). Runs through the gap to IDLE.
  task automatic finish_txn(input int g, input int d, input bit nack,
                            input logic [7:0] rd, input bit keep);
    bit bad = 1'b0;
    bit tmo = (d > TO);
    for (int w = 1; w <= TO; w++) begin
      if (w == d) begin
        bus.m_done = 1'b1; bus.m_nack = nack; bus.m_rdata = rd;
        #1;
        if (w == TO) chk("race_no_abort", 32'(bus.m_abort), 0);
      end else if (w == TO) begin
        chk("abort_pulse", 32'(bus.m_abort), 1);
      end else if (bus.m_abort !== 1'b0 || bus.done != '0 || bus.m_start !== (w == 1)) begin
        bad = 1'b1;
      end
      tick();
      if (w == d) begin
        bus.m_done = 1'b0; bus.m_nack = 1'b0;
        break;
      end
    end
    chk("wait_quiet", 32'(bad), 0);
    if (!tmo) rdata_m = rd;
    // done cycle
    chk("done", 32'(bus.done), 32'(1 << g));
    chk("err", 32'(bus.err), 32'(tmo ? 1'b1 : nack));
    chk("timeout", 32'(bus.timeout), 32'(tmo));
    chk("rdata", 32'(bus.rdata), 32'(rdata_m));
    chk("gnt_resp", 32'(bus.gnt), 32'(1 << g));
    chk("abort_resp", 32'(bus.m_abort), 0);
    ptr_m = (g + 1) % N;
    if (!keep) bus.req[g] = 1'b0;
    tick();
    // gap cycle 1
    chk("done_clr", 32'(bus.done), 0);
    chk("err_clr", 32'({bus.err, bus.timeout}), 0);
    chk("gnt_clr", 32'(bus.gnt), 0);
    chk("busy_gap", 32'(bus.busy), 1);
    // a stray m_done during the gap must be ignored
    bus.m_done = 1'b1; bus.m_rdata = ~rd;
    tick();
    bus.m_done = 1'b0;
    for (int k = 2; k < GAP; k++) tick();
    chk("gap_end_busy", 32'(bus.busy), 1);
    chk("gap_end_gnt", 32'(bus.gnt), 0);
    chk("gap_rdata_hold", 32'(bus.rdata), 32'(rdata_m));
    tick();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_done", 32'(bus.done), 0);
  endtask

  initial begin
    int g;
    n_chk = 0; n_pass = 0; n_fail = 0;
    ptr_m = 0; rdata_m = '0;
    reset = 1'b1;
    bus.req = '0; bus.req_rw = '0; bus.req_chip = '0; bus.req_reg = '0; bus.req_wdata = '0;
    bus.m_done = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = '0;
    for (int i = 0; i < N; i++) begin
      rw_m[i] = 1'b0; chip_m[i] = '0; reg_m[i] = '0; wd_m[i] = '0;
    end
    tick(); tick();

    // reset state
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_flags", 32'({bus.err, bus.timeout, bus.m_start, bus.m_abort}), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_desc", 32'({bus.m_rw, bus.m_chip, bus.m_reg, bus.m_wdata}), 0);
    reset = 1'b0;
    tick();

    // single write, requester 0
    set_desc(0, 1'b0, 7'h39, 8'h41, 8'h10);
    bus.req = 2'b01;
    start_txn(g);
    finish_txn(g, 50, 1'b0, 8'h00, 1'b0);

    // read, requester 1
    set_desc(1, 1'b1, 7'h39, 8'h42, 8'h00);
    bus.req = 2'b10;
    start_txn(g);
    finish_txn(g, 20, 1'b0, 8'h5A, 1'b0);
    chk("rdata_held", 32'(bus.rdata), 32'h5A);

    // contention: both requesters hold req for four transactions -> 0,1,0,1
    set_desc(0, 1'b0, 7'h10, 8'h01, 8'hAA);
    set_desc(1, 1'b1, 7'h20, 8'h02, 8'h55);
    bus.req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      start_txn(g);
      finish_txn(g, 5 + 3 * t, 1'b0, 8'(8'h30 + t), 1'b1);
    end
    bus.req = 2'b00;

    // timeout: master never answers
    bus.req = 2'b01;
    start_txn(g);
    finish_txn(g, TO + 1, 1'b0, 8'h00, 1'b0);

    // NACK
    bus.req = 2'b10;
    start_txn(g);
    finish_txn(g, 30, 1'b1, 8'hA5, 1'b0);

    // m_done on the expiry cycle wins over the watchdog
    bus.req = 2'b01;
    start_txn(g);
    finish_txn(g, TO, 1'b0, 8'h3C, 1'b0);

    // dropping req after grant does not cancel
    bus.req = 2'b10;
    start_txn(g);
    bus.req = 2'b00;
    finish_txn(g, 10, 1'b0, 8'hC3, 1'b0);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      int d;
      for (int i = 0; i < N; i++)
        set_desc(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
      bus.req = N'($urandom_range(1, (1 << N) - 1));
      d = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(1, TO));
      start_txn(g);
      finish_txn(g, d, 1'($urandom), 8'($urandom), 1'b0);
    end

    // reset mid-WAIT: move the pointer to 1, start requester 1, then reset
    bus.req = 2'b01;
    start_txn(g);
    finish_txn(g, 5, 1'b0, 8'h11, 1'b0);
    bus.req = 2'b10;
    start_txn(g);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ptr_m = 0; rdata_m = '0;
    chk("mid_rst_gnt", 32'(bus.gnt), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_desc", 32'({bus.m_chip, bus.m_start, bus.m_abort}), 0);
    bus.req = 2'b00;
    tick();
    chk("post_rst_done", 32'(bus.done), 0);
    chk("post_rst_busy", 32'(bus.busy), 0);
    bus.req = 2'b11;
    start_txn(g);
    chk("post_rst_gnt0", 32'(bus.gnt), 32'h1);
    finish_txn(g, 8, 1'b0, 8'h77, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
